// File: rtl/pifo_task_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pifo_task_arbiter
// Purpose  : Multi-port request front-end for the SRAM-based vPIFO core.
//            Each port queues push/pop requests in a private task FIFO. A
//            tree-aware round-robin arbiter issues one command per cycle to
//            the core. Pop results are routed back to the issuing port.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_clk, i_arst_n        clock, asynchronous active-low reset
//   i_push/i_pop           per-port request strobes
//   i_tree_id/i_push_data  per-port target tree and push payload
//   o_task_fifo_full       per-port FIFO full flag
//   o_cmd_*, i_cmd_ready   command handshake towards the PIFO core
//   i_busy_tree            per-tree busy mask from the core
//   i_rsp_*                pop result from the core (tagged with port)
//   o_pop_valid/o_pop_data per-port pop result, registered
//   o_drop_cnt             per-port saturating drop counters
// Build option
//   PIFO_ARB_DROP_CNT_EN   when defined, builds the drop counters;
//                          otherwise o_drop_cnt is tied to zero
// ============================================================================
module pifo_task_arbiter #(
    parameter int NPORT = 4,
    parameter int NTREE = 4,
    parameter int PTW   = 8,
    parameter int DEPTH = 4,
    parameter int CNTW  = 16,
    localparam int TIDW = $clog2(NTREE),
    localparam int PW   = $clog2(NPORT)
) (
    input  logic                  i_clk,
    input  logic                  i_arst_n,
    input  logic [NPORT-1:0]      i_push,
    input  logic [NPORT-1:0]      i_pop,
    input  logic [NPORT*TIDW-1:0] i_tree_id,
    input  logic [NPORT*PTW-1:0]  i_push_data,
    output logic [NPORT-1:0]      o_task_fifo_full,
    output logic                  o_cmd_valid,
    input  logic                  i_cmd_ready,
    output logic                  o_cmd_push,
    output logic                  o_cmd_pop,
    output logic [TIDW-1:0]       o_cmd_tree,
    output logic [PTW-1:0]        o_cmd_data,
    output logic [PW-1:0]         o_cmd_tag,
    input  logic [NTREE-1:0]      i_busy_tree,
    input  logic                  i_rsp_valid,
    input  logic [PW-1:0]         i_rsp_tag,
    input  logic [PTW-1:0]        i_rsp_data,
    output logic [NPORT-1:0]      o_pop_valid,
    output logic [NPORT*PTW-1:0]  o_pop_data,
    output logic [NPORT*CNTW-1:0] o_drop_cnt
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef struct packed {
        logic            push;
        logic            pop;
        logic [TIDW-1:0] tree;
        logic [PTW-1:0]  data;
    } entry_t;

    logic [NPORT-1:0]     w_req, w_wr, w_full, w_elig, w_deq;
    entry_t [NPORT-1:0]   w_head;
    entry_t               w_gnt_head;
    logic [PW-1:0]        rr_ptr_q, rr_ptr_d, w_grant;
    logic                 w_found, w_issue;
    logic [NPORT-1:0]     pop_valid_q;
    logic [NPORT*PTW-1:0] pop_data_q;

    // ------------------------------------------------------------------
    // Per-port task FIFOs
    // ------------------------------------------------------------------
    for (genvar p = 0; p < NPORT; p++) begin : g_port
        entry_t        mem_q [DEPTH];
        logic [AW-1:0] wr_ptr_q, rd_ptr_q;
        logic [AW:0]   cnt_q, cnt_d;
        entry_t        w_new;

        assign w_req[p]  = i_push[p] | i_pop[p];
        // Full is judged on the registered count only, so a request arriving
        // while full is dropped even if this port dequeues in the same cycle.
        assign w_full[p] = (cnt_q == FULL_CNT);
        assign w_wr[p]   = w_req[p] & ~w_full[p];
        assign w_deq[p]  = w_issue & (w_grant == PW'(p));
        assign w_head[p] = mem_q[rd_ptr_q];
        assign w_elig[p] = (cnt_q != '0) & ~i_busy_tree[w_head[p].tree];

        always_comb begin
            w_new.push = i_push[p];
            w_new.pop  = i_pop[p];
            w_new.tree = i_tree_id[p*TIDW +: TIDW];
            // Pop-only entries carry no payload.
            w_new.data = i_push[p] ? i_push_data[p*PTW +: PTW] : '0;
        end

        always_comb begin
            cnt_d = cnt_q;
            if (w_wr[p] & ~w_deq[p]) begin
                cnt_d = cnt_q + (AW+1)'(1);
            end else if (~w_wr[p] & w_deq[p]) begin
                cnt_d = cnt_q - (AW+1)'(1);
            end
        end

        always_ff @(posedge i_clk or negedge i_arst_n) begin
            if (!i_arst_n) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                if (w_wr[p]) begin
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                end
                if (w_deq[p]) begin
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                end
                cnt_q <= cnt_d;
            end
        end

        // Storage needs no reset: an entry is only read once counted.
        always_ff @(posedge i_clk) begin
            if (w_wr[p]) begin
                mem_q[wr_ptr_q] <= w_new;
            end
        end
    end

    // ------------------------------------------------------------------
    // Round-robin arbitration over eligible heads, starting at rr_ptr
    // ------------------------------------------------------------------
    always_comb begin : p_arb
        logic [PW-1:0] idx;
        w_found = 1'b0;
        w_grant = '0;
        idx     = '0;
        for (int i = 0; i < NPORT; i++) begin
            idx = PW'((int'(rr_ptr_q) + i) % NPORT);
            if (!w_found && w_elig[idx]) begin
                w_found = 1'b1;
                w_grant = idx;
            end
        end
    end

    assign w_issue    = w_found & i_cmd_ready;
    assign w_gnt_head = w_head[w_grant];

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (w_issue) begin
            rr_ptr_d = (w_grant == PW'(NPORT-1)) ? '0 : w_grant + PW'(1);
        end
    end

    // Command fields are forced to zero while nothing is offered so stale
    // FIFO contents never appear on the core interface.
    assign o_cmd_valid = w_found;
    assign o_cmd_push  = w_found & w_gnt_head.push;
    assign o_cmd_pop   = w_found & w_gnt_head.pop;
    assign o_cmd_tree  = w_found ? w_gnt_head.tree : '0;
    assign o_cmd_data  = w_found ? w_gnt_head.data : '0;
    assign o_cmd_tag   = w_found ? w_grant : '0;

    assign o_task_fifo_full = w_full;

    // ------------------------------------------------------------------
    // Arbiter pointer and response routing
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            rr_ptr_q    <= '0;
            pop_valid_q <= '0;
            pop_data_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            pop_valid_q <= '0;
            if (i_rsp_valid) begin
                pop_valid_q[i_rsp_tag]                   <= 1'b1;
                pop_data_q[int'(i_rsp_tag)*PTW +: PTW]   <= i_rsp_data;
            end
        end
    end

    assign o_pop_valid = pop_valid_q;
    assign o_pop_data  = pop_data_q;

    // ------------------------------------------------------------------
    // Optional saturating drop counters
    // ------------------------------------------------------------------
`ifdef PIFO_ARB_DROP_CNT_EN
    logic [NPORT*CNTW-1:0] drop_cnt_q;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            drop_cnt_q <= '0;
        end else begin
            for (int p = 0; p < NPORT; p++) begin
                if (w_req[p] & w_full[p] & ~(&drop_cnt_q[p*CNTW +: CNTW])) begin
                    drop_cnt_q[p*CNTW +: CNTW] <= drop_cnt_q[p*CNTW +: CNTW] + CNTW'(1);
                end
            end
        end
    end

    assign o_drop_cnt = drop_cnt_q;
`else
    assign o_drop_cnt = '0;
`endif

endmodule
`default_nettype wire
